// File: rtl/vga_pkg.sv
// Shared VGA definitions: visible-area geometry, coordinate and colour types.
package vga_pkg;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;
endpackage

// File: rtl/vsync_edge.sv
// Registers vsync and flags its falling edge; the start-of-frame strobe for frame-rate logic.
module vsync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vsync_i,
    output logic fall_o
);
    logic vsync_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsync_prev_q <= 1'b1;
        end else begin
            vsync_prev_q <= vsync_i;
        end
    end

    assign fall_o = vsync_prev_q & ~vsync_i;
endmodule

// File: rtl/sprite_render_pipe.sv
// Two-stage pixel pipeline: draws one ROM bitmap sprite over a flat background,
// keeping sync and colour aligned, with the sprite position latched once per frame.
module sprite_render_pipe
    import vga_pkg::*;
#(
    parameter int          SPRITE_W = 20,
    parameter int          SPRITE_H = 22,
    parameter int          ADDR_W   = $clog2(SPRITE_H),
    parameter logic [11:0] FG_RGB   = 12'h555,
    parameter logic [11:0] BG_RGB   = 12'hFFF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                hsync_i,
    input  logic                vsync_i,
    input  logic                visible_i,
    input  logic [9:0]          position_x_i,
    input  logic [9:0]          position_y_i,
    input  logic [9:0]          sprite_x_i,
    input  logic [9:0]          sprite_y_i,
    output logic [ADDR_W-1:0]   rom_addr_o,
    input  logic [SPRITE_W-1:0] rom_data_i,
    output logic                frame_tick_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic [3:0]          vga_red_o,
    output logic [3:0]          vga_green_o,
    output logic [3:0]          vga_blue_o
);
    localparam int          IDX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam logic [10:0] W_11  = 11'(SPRITE_W);
    localparam logic [10:0] H_11  = 11'(SPRITE_H);

    coord_t sx_q, sy_q;
    logic   tick_q;
    logic   vsync_fall;

    vsync_edge u_vsync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vsync_i(vsync_i),
        .fall_o (vsync_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sx_q   <= '0;
            sy_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= vsync_fall;
            if (vsync_fall) begin
                sx_q <= sprite_x_i;
                sy_q <= sprite_y_i;
            end
        end
    end

    // Stage 0: box test at 11 bits so sx_q+SPRITE_W cannot wrap past column 1023.
    logic [10:0] px, py, sx_w, sy_w;
    logic        in_box_d;
    logic [4:0]  col_d;

    assign px   = {1'b0, position_x_i};
    assign py   = {1'b0, position_y_i};
    assign sx_w = {1'b0, sx_q};
    assign sy_w = {1'b0, sy_q};

    assign in_box_d = visible_i
                   && (px >= sx_w) && (px < sx_w + W_11)
                   && (py >= sy_w) && (py < sy_w + H_11)
                   && (px < 11'(H_VISIBLE)) && (py < 11'(V_VISIBLE));

    assign col_d      = 5'(position_x_i - sx_q);
    assign rom_addr_o = in_box_d ? ADDR_W'(position_y_i - sy_q) : '0;

    // Stage 1 registers; the ROM answers during this stage.
    logic       hsync_1_q, vsync_1_q, visible_1_q, in_box_1_q;
    logic [4:0] col_1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsync_1_q   <= 1'b1;
            vsync_1_q   <= 1'b1;
            visible_1_q <= 1'b0;
            in_box_1_q  <= 1'b0;
            col_1_q     <= '0;
        end else begin
            hsync_1_q   <= hsync_i;
            vsync_1_q   <= vsync_i;
            visible_1_q <= visible_i;
            in_box_1_q  <= in_box_d;
            col_1_q     <= col_d;
        end
    end

    // Stage 2: pick the pixel bit (MSB is leftmost) and resolve colour.
    logic [IDX_W-1:0] bit_idx;
    logic             hit_d;
    rgb_t             rgb_d, rgb_q;
    logic             hsync_2_q, vsync_2_q;

    assign bit_idx = IDX_W'(SPRITE_W - 1) - IDX_W'(col_1_q);
    assign hit_d   = in_box_1_q & rom_data_i[bit_idx];

    always_comb begin
        rgb_d = '0;
        if (hit_d) begin
            rgb_d = rgb_t'(FG_RGB);
        end else if (visible_1_q) begin
            rgb_d = rgb_t'(BG_RGB);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsync_2_q <= 1'b1;
            vsync_2_q <= 1'b1;
            rgb_q     <= '0;
        end else begin
            hsync_2_q <= hsync_1_q;
            vsync_2_q <= vsync_1_q;
            rgb_q     <= rgb_d;
        end
    end

    assign hsync_o      = hsync_2_q;
    assign vsync_o      = vsync_2_q;
    assign vga_red_o    = rgb_q.red;
    assign vga_green_o  = rgb_q.green;
    assign vga_blue_o   = rgb_q.blue;
    assign frame_tick_o = tick_q;
endmodule

// File: doc/sprite_render_pipe.md
Name: sprite_render_pipe

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator.
- Consumes the timing generator's hsync/vsync/visible and 10-bit x/y position. Draws one bitmap sprite (the dinosaur) from an external synchronous row ROM over a flat background.
- Drives the VGA pins with sync and colour aligned through a fixed 2-cycle pipeline.
- Latches the game's requested sprite position once per frame, so a sprite never tears mid-frame, and emits a per-frame tick for game logic.

Parameters:
- SPRITE_W, 20, sprite width in pixels (bits per ROM row), 1..32
- SPRITE_H, 22, sprite height in rows (ROM depth)
- ADDR_W, $clog2(SPRITE_H), ROM address width (derived)
- FG_RGB, 12'h555, sprite colour {r,g,b} 4 bits each
- BG_RGB, 12'hFFF, background colour in visible area

Ports:
- clk_i  in  1  pixel clock (same as timing generator)
- rst_ni  in  1  reset, asynchronous, active-low
- hsync_i  in  1  horizontal sync from timing generator (active low)
- vsync_i  in  1  vertical sync from timing generator (active low)
- visible_i  in  1  pixel in 640x480 active area
- position_x_i  in  10  current pixel column
- position_y_i  in  10  current pixel row
- sprite_x_i  in  10  requested sprite top-left column (game logic)
- sprite_y_i  in  10  requested sprite top-left row
- rom_addr_o  out  ADDR_W  sprite row address, combinational from stage 0
- rom_data_i  in  SPRITE_W  row bitmap; MSB = leftmost pixel; valid 1 cycle after address
- frame_tick_o  out  1  one-cycle pulse per frame
- hsync_o  out  1  delayed hsync to pin
- vsync_o  out  1  delayed vsync to pin
- vga_red_o / vga_green_o / vga_blue_o  out  4 each  pixel colour

Behaviour:
- Reset (async assert, sync release): hsync_o=1, vsync_o=1, rgb=0, frame_tick_o=0, latched sprite pos=(0,0), all pipeline regs cleared (visible=0, hit=0, syncs=1). Applies immediately mid-frame. After release, outputs track inputs after 2 cycles.
- Frame latch: registered vsync_prev. When vsync_prev=1 and vsync_i=0 (falling edge), sx_q<=sprite_x_i, sy_q<=sprite_y_i, and frame_tick_o=1 on the next cycle for exactly one cycle. sprite_x_i/y_i changes at any other time are ignored until the next edge.
- Stage 0 (combinational):
  - dx=position_x_i-sx_q; dy=position_y_i-sy_q, both 11-bit.
  - in_box = visible_i AND x>=sx_q AND x<sx_q+SPRITE_W AND y>=sy_q AND y<sy_q+SPRITE_H. All sums computed at 11 bits, so there is no wrap-around.
  - rom_addr_o = dy[ADDR_W-1:0] when in_box, else 0.
- Stage 1 (reg): hsync, vsync, visible, in_box, col=dx[4:0].
- Stage 2 (reg):
  - hit = in_box_1 AND rom_data_i[SPRITE_W-1-col_1].
  - rgb = FG_RGB if hit; else BG_RGB if visible_1; else 0 (blanking mandatory).
  - syncs copied from stage 1.
- Latency: every output is exactly 2 clk after its timer inputs; sync/colour alignment is preserved.
- Edges:
  - Sprite crossing right/bottom edge is clipped by visible_i.
  - sx_q>=640 or sy_q>=480 gives no hit.
  - Hit never aliases to x<sx_q.
- No handshakes; the block runs every cycle and has no stall.

Decomposition:
- vga_pkg:
  - H_VISIBLE=640, V_VISIBLE=480
  - coord_t (logic [9:0])
  - rgb_t packed struct {red, green, blue : logic [3:0]}
- One sub-module: vsync_edge (registers vsync, outputs fall pulse). This is reused for other frame-rate logic.

Test Plan:
1. rst_ni=0 mid-frame while visible/hit -> same cycle hsync_o=1, vsync_o=1, rgb=0, frame_tick_o=0. Release -> first valid colour 2 cycles after first visible input.
2. hsync_i falls at cycle N -> hsync_o falls at N+2. Same for vsync; visible region start (x=0) gives BG_RGB at N+2.
3. Latched sprite (100,200), ROM row0=20'h80001, x=100,y=200 -> rom_addr_o=0, rgb=FG at +2. x=101 -> BG. x=119 -> FG. x=120 -> BG. x=99 -> BG.
4. sprite_x_i 100->300 mid-frame -> drawing stays at 100. vsync_i falls -> frame_tick_o high exactly 1 cycle. Next frame draws at 300.
5. visible_i=0 with position inside box -> rgb=0, not FG/BG.
6. sprite (630,470) -> cols 630..639 and rows 470..479 drawn. x=0..9 of the next line, and rows 0..11, show BG (no wrap). rom_addr_o=0 outside box.
